// File: rtl/sdram_port_16b.sv
// 16-bit client adapter for one bank port of the 8-bit SDRAM controller (BL=2).
// A single-word request from the core side becomes one two-byte burst. Read
// bytes are assembled into one word. Write bytes are served two cycles after
// each fetch strobe from the controller.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for req while the controller is ready
// RD0    | read issued, rden_b held, waiting for the low byte
// RD1    | low byte captured, waiting for the high byte
// WR0    | write issued, wren_b held, waiting for the first fetch
// WR1    | first fetch seen, waiting for the second fetch
// WDRAIN | both fetches seen, waiting until the high byte is on wr_data_b
// DONE   | ack pulse, back to IDLE next cycle
module sdram_port_16b #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 2047
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_rdy_n,
    input  logic        req,
    input  logic        we,
    input  logic [22:0] waddr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        rden_b,
    output logic        wren_b,
    output logic [31:0] addr_b,
    input  logic        valid_b,
    input  logic        fetch_b,
    input  logic [7:0]  rd_data,
    output logic [7:0]  wr_data_b
);

    // The timeout counter is never narrower than 11 bits.
    localparam int CW = ($clog2(TIMEOUT + 1) < 11) ? 11 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD0    = 3'd1,
        RD1    = 3'd2,
        WR0    = 3'd3,
        WR1    = 3'd4,
        WDRAIN = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    lo_byte;
    logic [15:0]   wdata_q;
    logic          fetch_d1;
    logic          fetch_d2;
    logic          byte_idx;
    logic          drain_idx;
    logic          in_wr_fetch;

    // Fetch strobes only count while a write is waiting for them.
    assign in_wr_fetch = (state == WR0) || (state == WR1);

    // Transaction FSM, fetch delay line and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lo_byte   <= '0;
            wdata_q   <= '0;
            fetch_d1  <= 1'b0;
            fetch_d2  <= 1'b0;
            byte_idx  <= 1'b0;
            drain_idx <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            rden_b    <= 1'b0;
            wren_b    <= 1'b0;
            addr_b    <= '0;
            wr_data_b <= '0;
        end else begin
            ack      <= 1'b0;
            err      <= 1'b0;
            fetch_d1 <= fetch_b && in_wr_fetch;
            fetch_d2 <= fetch_d1;

            // Byte k is registered one cycle after fetch k is seen, so it is
            // on the pins two cycles after the strobe.
            if (fetch_d1) begin
                wr_data_b <= byte_idx ? wdata_q[15:8] : wdata_q[7:0];
                byte_idx  <= 1'b1;
            end
            if (fetch_d2) begin
                drain_idx <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req && !ram_rdy_n) begin
                        addr_b    <= BASE_ADDR + {8'b0, waddr, 1'b0};
                        wdata_q   <= wdata;
                        cnt       <= '0;
                        byte_idx  <= 1'b0;
                        drain_idx <= 1'b0;
                        fetch_d1  <= 1'b0;
                        fetch_d2  <= 1'b0;
                        busy      <= 1'b1;
                        if (we) begin
                            wren_b <= 1'b1;
                            state  <= WR0;
                        end else begin
                            rden_b <= 1'b1;
                            state  <= RD0;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    if (cnt == CNT_LAST) begin
                        // Abort: drop the request and discard anything in flight.
                        rden_b   <= 1'b0;
                        wren_b   <= 1'b0;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        fetch_d1 <= 1'b0;
                        fetch_d2 <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        case (state)
                            RD0: if (valid_b) begin
                                lo_byte <= rd_data;
                                rden_b  <= 1'b0;
                                state   <= RD1;
                            end
                            RD1: if (valid_b) begin
                                rdata <= {rd_data, lo_byte};
                                ack   <= 1'b1;
                                state <= DONE;
                            end
                            WR0: if (fetch_b) begin
                                wren_b <= 1'b0;
                                state  <= WR1;
                            end
                            WR1: if (fetch_b) begin
                                state <= WDRAIN;
                            end
                            WDRAIN: if (fetch_d2 && drain_idx) begin
                                ack   <= 1'b1;
                                state <= DONE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
